reg_8_bit_shift_out: RTL and testbench



---
 rtl/reg_8_bit_shift_out.sv | 141 ++++++++++++++
 tb/tb_reg_8_bit_shift_out.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_8_bit_shift_out.sv
// reg_8_bit_shift_out: serialises a parallel byte LSB first, framed by one
// start bit (low) and STOP_BITS stop bits (high), each bit held for
// CLKS_PER_BIT clocks. START/BUSY/DONE handshake toward the control unit.
// Every output comes straight from a flop, so IN and START never reach the
// serial line combinationally.
module reg_8_bit_shift_out #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int STOP_BITS    = 1
) (
    input  logic              CLK,
    input  logic              CLEAR_N,
    input  logic [DATA_W-1:0] IN,
    input  logic              START,
    output logic              SER_OUT,
    output logic              BUSY,
    output logic              DONE
);

    localparam int TICK_W = $clog2(CLKS_PER_BIT) + 1;
    localparam int BIT_W  = $clog2(DATA_W + STOP_BITS);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START_BIT,
        ST_DATA,
        ST_STOP
    } state_t;

    state_t              state_q, state_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                ser_out_q, ser_out_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    // State register and registered outputs; reset abandons any frame in flight.
    always_ff @(posedge CLK or negedge CLEAR_N) begin
        if (!CLEAR_N) begin
            state_q   <= ST_IDLE;
            tick_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            ser_out_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            ser_out_q <= ser_out_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next-state logic; outputs are decoded from the next state so they are
    // valid in the same cycle the flops enter that state.
    // The bit counter is reused in STOP to count stop bits, so the tick
    // counter only ever has to span one bit period.
    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        done_d    = 1'b0;
        ser_out_d = 1'b1;
        busy_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    shift_d = IN;
                    tick_d  = '0;
                    bit_d   = '0;
                    state_d = ST_START_BIT;
                end
            end
            ST_START_BIT: begin
                if (tick_q == TICK_LAST) begin
                    tick_d  = '0;
                    bit_d   = '0;
                    state_d = ST_DATA;
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            ST_DATA: begin
                if (tick_q == TICK_LAST) begin
                    tick_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == DATA_LAST) begin
                        bit_d   = '0;
                        state_d = ST_STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            ST_STOP: begin
                if (tick_q == TICK_LAST) begin
                    tick_d = '0;
                    if (bit_q == STOP_LAST) begin
                        bit_d   = '0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                tick_d  = '0;
                bit_d   = '0;
            end
        endcase

        case (state_d)
            ST_START_BIT: ser_out_d = 1'b0;
            ST_DATA:      ser_out_d = shift_d[0];
            default:      ser_out_d = 1'b1;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    assign SER_OUT = ser_out_q;
    assign BUSY    = busy_q;
    assign DONE    = done_q;

endmodule

// File: tb/tb_reg_8_bit_shift_out.sv
// tb_reg_8_bit_shift_out: directed frame vectors for the default
// configuration, plus hand-written sequences for back-to-back frames,
// ignored starts, mid-frame reset and a one-clock-per-bit, two-stop-bit build.
module tb_reg_8_bit_shift_out;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_a, in_b;
    logic       start_a, start_b;
    logic       ser_a, busy_a, done_a;
    logic       ser_b, busy_b, done_b;

    int checks   = 0;
    int failures = 0;

    // Expected frame bits: bit i is the i-th serial bit on the line.
    typedef struct {
        logic [7:0]  data;
        logic [10:0] exp_bits;
        int          poke_cycle;
        string       name;
    } vec_t;

    vec_t vecs[5];

    // Default configuration: 4 clocks per bit, one stop bit.
    reg_8_bit_shift_out dut_a (
        .CLK     (clk),
        .CLEAR_N (rst_n),
        .IN      (in_a),
        .START   (start_a),
        .SER_OUT (ser_a),
        .BUSY    (busy_a),
        .DONE    (done_a)
    );

    // Fast configuration: one clock per bit, two stop bits.
    reg_8_bit_shift_out #(
        .DATA_W       (8),
        .CLKS_PER_BIT (1),
        .STOP_BITS    (2)
    ) dut_b (
        .CLK     (clk),
        .CLEAR_N (rst_n),
        .IN      (in_b),
        .START   (start_b),
        .SER_OUT (ser_b),
        .BUSY    (busy_b),
        .DONE    (done_b)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    function automatic logic ser_of(input int sel);
        return (sel == 0) ? ser_a : ser_b;
    endfunction

    function automatic logic busy_of(input int sel);
        return (sel == 0) ? busy_a : busy_b;
    endfunction

    function automatic logic done_of(input int sel);
        return (sel == 0) ? done_a : done_b;
    endfunction

    task automatic checkOutput(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %b, expected %b at t=%0t", name, actual, expected, $time);
        end
    endtask

    // Present a byte with START high, let one rising edge sample it, then
    // drop START unless the caller wants it held for back-to-back frames.
    task automatic applyStimulus(input int sel, input logic [7:0] data, input bit keep);
        if (sel == 0) begin
            in_a    = data;
            start_a = 1'b1;
        end else begin
            in_b    = data;
            start_b = 1'b1;
        end
        @(posedge clk);
        #1;
        if (!keep) begin
            if (sel == 0) start_a = 1'b0;
            else          start_b = 1'b0;
        end
    endtask

    // Walk every cycle of a frame body, checking the serial level, BUSY high
    // and DONE low. Optionally pokes IN/START mid-frame or drops a held START.
    task automatic checkBody(input int sel, input logic [10:0] exp_bits, input int n_bits,
                             input int cpb, input int poke_cycle, input int drop_cycle,
                             input string name);
        for (int c = 0; c < n_bits * cpb; c++) begin
            @(negedge clk);
            checkOutput({name, "_ser"}, ser_of(sel), exp_bits[c / cpb]);
            checkOutput({name, "_busy"}, busy_of(sel), 1'b1);
            checkOutput({name, "_done"}, done_of(sel), 1'b0);
            if (sel == 0 && poke_cycle >= 0 && c == poke_cycle) begin
                in_a    = 8'hFF;
                start_a = 1'b1;
            end
            if (sel == 0 && poke_cycle >= 0 && c == poke_cycle + 1) begin
                start_a = 1'b0;
            end
            if (sel == 0 && drop_cycle >= 0 && c == drop_cycle) begin
                start_a = 1'b0;
            end
        end
    endtask

    task automatic checkDoneCycle(input int sel, input string name);
        @(negedge clk);
        checkOutput({name, "_done_pulse"}, done_of(sel), 1'b1);
        checkOutput({name, "_done_busy"}, busy_of(sel), 1'b0);
        checkOutput({name, "_done_ser"}, ser_of(sel), 1'b1);
    endtask

    task automatic checkIdleCycle(input int sel, input string name);
        @(negedge clk);
        checkOutput({name, "_idle_done"}, done_of(sel), 1'b0);
        checkOutput({name, "_idle_busy"}, busy_of(sel), 1'b0);
        checkOutput({name, "_idle_ser"}, ser_of(sel), 1'b1);
    endtask

    // Main sequence: reset, vector table, then the multi-cycle corner cases.
    initial begin
        vecs[0] = '{8'hA5, 11'b01101001010, -1, "frame_A5"};
        vecs[1] = '{8'h3C, 11'b01001111000,  9, "frame_3C_poke"};
        vecs[2] = '{8'h00, 11'b01000000000, -1, "frame_00"};
        vecs[3] = '{8'hFF, 11'b01111111110, -1, "frame_FF"};
        vecs[4] = '{8'h55, 11'b01010101010, -1, "frame_55"};

        rst_n   = 1'b1;
        in_a    = 8'h00;
        in_b    = 8'h00;
        start_a = 1'b0;
        start_b = 1'b0;
        #1;
        rst_n   = 1'b0;
        in_a    = 8'hFF;
        in_b    = 8'hFF;
        start_a = 1'b1;
        start_b = 1'b1;

        // Reset held with START asserted: both instances must stay quiet.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("reset_ser_a", ser_a, 1'b1);
            checkOutput("reset_busy_a", busy_a, 1'b0);
            checkOutput("reset_done_a", done_a, 1'b0);
            checkOutput("reset_ser_b", ser_b, 1'b1);
            checkOutput("reset_busy_b", busy_b, 1'b0);
            checkOutput("reset_done_b", done_b, 1'b0);
        end
        start_a = 1'b0;
        start_b = 1'b0;
        rst_n   = 1'b1;
        checkIdleCycle(0, "post_reset");

        // Table-driven single frames in the default configuration.
        for (int v = 0; v < 5; v++) begin
            applyStimulus(0, vecs[v].data, 1'b0);
            checkBody(0, vecs[v].exp_bits, 10, 4, vecs[v].poke_cycle, -1, vecs[v].name);
            checkDoneCycle(0, vecs[v].name);
            checkIdleCycle(0, vecs[v].name);
        end

        // Back-to-back: START held; the second start bit follows the DONE cycle.
        applyStimulus(0, 8'h01, 1'b1);
        in_a = 8'h80;
        checkBody(0, 11'b01000000010, 10, 4, -1, -1, "b2b_first");
        checkDoneCycle(0, "b2b_first");
        checkBody(0, 11'b01100000000, 10, 4, -1, 0, "b2b_second");
        checkDoneCycle(0, "b2b_second");
        checkIdleCycle(0, "b2b_second");

        // Fast build: 11-cycle frame of all-zero data with two stop bits.
        applyStimulus(1, 8'h00, 1'b0);
        checkBody(1, 11'b11000000000, 11, 1, -1, -1, "fast_00");
        checkDoneCycle(1, "fast_00");
        checkIdleCycle(1, "fast_00");

        // Mid-frame reset during data bit 3 of 8'h55, between clock edges.
        applyStimulus(0, 8'h55, 1'b0);
        for (int c = 0; c < 17; c++) begin
            @(negedge clk);
        end
        checkOutput("midreset_before_ser", ser_a, 1'b0);
        checkOutput("midreset_before_busy", busy_a, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_async_ser", ser_a, 1'b1);
        checkOutput("midreset_async_busy", busy_a, 1'b0);
        checkOutput("midreset_async_done", done_a, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        checkIdleCycle(0, "midreset_release");
        checkIdleCycle(0, "midreset_quiet");
        applyStimulus(0, 8'h55, 1'b0);
        checkBody(0, 11'b01010101010, 10, 4, -1, -1, "midreset_refrm");
        checkDoneCycle(0, "midreset_refrm");
        checkIdleCycle(0, "midreset_refrm");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
